aeolus_control_sequencer: RTL and testbench

Multi-cycle control unit for the Aeolus 8-bit CPU datapath: program counter, instruction register, ALU, accumulator, switch input and output latch. It sequences every instruction through FETCH/DECODE/EXEC. It also provides free-run, single-step and halt control, so programs can be observed instruction-by-instruction on the board. It sits between instruction memory and the datapath inside the CPU top level. All datapath control strobes originate here.

---
 rtl/aeolus_control_sequencer_if.sv | 30 +++
 rtl/aeolus_control_sequencer.sv | 148 ++++++++++++++
 tb/tb_aeolus_control_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aeolus_control_sequencer_if.sv
// Control-side bundle between the Aeolus sequencer and the CPU top level:
// run/step controls, instruction byte and zero flag in; datapath strobes out.
interface aeolus_control_sequencer_if;
    logic       run;
    logic       step;
    logic [7:0] instr;
    logic       zeroFlag;

    logic       pcInc;
    logic       pcLoad;
    logic       irLoad;
    logic [2:0] aluOp;
    logic       accWrite;
    logic [1:0] accSel;
    logic       outLoad;
    logic       halted;
    logic [2:0] state;

    // Driver of controls / consumer of strobes (CPU top level, bench).
    modport master (
        output run, step, instr, zeroFlag,
        input  pcInc, pcLoad, irLoad, aluOp, accWrite, accSel, outLoad, halted, state
    );

    // The sequencer itself.
    modport slave (
        input  run, step, instr, zeroFlag,
        output pcInc, pcLoad, irLoad, aluOp, accWrite, accSel, outLoad, halted, state
    );
endinterface

// File: rtl/aeolus_control_sequencer.sv
// Aeolus multi-cycle control sequencer: steps each instruction through
// FETCH/DECODE/EXEC, with free-run, single-step and sticky HALT control.
// All outputs are a Moore decode of state, wait counter and opcode register
// (plus zeroFlag for the conditional jump, which is itself registered upstream).
module aeolus_control_sequencer #(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic                             boardCLK,
    input  logic                             reset,
    aeolus_control_sequencer_if.slave        bus
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StHalt   = 3'd4
    } state_e;

    localparam logic [WAIT_W-1:0] LastWait = WAIT_W'(MEM_WAIT - 1);
    localparam logic [3:0]        OpHalt   = 4'hF;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [3:0]        opcode_q, opcode_d;

    logic       pc_inc;
    logic       pc_load;
    logic       ir_load;
    logic [2:0] alu_op;
    logic       acc_write;
    logic [1:0] acc_sel;
    logic       out_load;
    logic       halted;

    // Only the opcode nibble is decoded here; the operand goes to the datapath.
    logic unused_operand;
    assign unused_operand = ^bus.instr[3:0];

    // State, fetch wait counter and opcode registers; reset is immediate.
    always_ff @(posedge boardCLK or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            wait_q   <= '0;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            opcode_q <= opcode_d;
        end
    end

    // Next-state logic: instruction sequencing and run/step/halt control.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        opcode_d = opcode_q;
        case (state_q)
            StIdle: begin
                if (bus.run || bus.step) begin
                    state_d = StFetch;
                    wait_d  = '0;
                end
            end
            StFetch: begin
                if (wait_q == LastWait) begin
                    opcode_d = bus.instr[7:4];
                    wait_d   = '0;
                    state_d  = StDecode;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StDecode: begin
                state_d = (opcode_q == OpHalt) ? StHalt : StExec;
            end
            StExec: begin
                // A held step re-triggers from IDLE, one instruction per visit.
                state_d = bus.run ? StFetch : StIdle;
                wait_d  = '0;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
                wait_d  = '0;
            end
        endcase
    end

    // Output decode: strobes from registered state, counter and opcode.
    always_comb begin
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        ir_load   = 1'b0;
        alu_op    = 3'd0;
        acc_write = 1'b0;
        acc_sel   = 2'd0;
        out_load  = 1'b0;
        halted    = 1'b0;
        case (state_q)
            StFetch: begin
                if (wait_q == LastWait) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                end
            end
            StExec: begin
                case (opcode_q)
                    4'h1: begin
                        acc_write = 1'b1;
                        acc_sel   = 2'd1;
                    end
                    4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        // Opcodes 2..7 map onto ALU ops 0..5.
                        acc_write = 1'b1;
                        acc_sel   = 2'd0;
                        alu_op    = opcode_q[2:0] - 3'd2;
                    end
                    4'h8: begin
                        acc_write = 1'b1;
                        acc_sel   = 2'd2;
                    end
                    4'h9: out_load = 1'b1;
                    4'hA: pc_load  = 1'b1;
                    4'hB: pc_load  = bus.zeroFlag;
                    default: ;
                endcase
            end
            StHalt: halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.pcInc    = pc_inc;
    assign bus.pcLoad   = pc_load;
    assign bus.irLoad   = ir_load;
    assign bus.aluOp    = alu_op;
    assign bus.accWrite = acc_write;
    assign bus.accSel   = acc_sel;
    assign bus.outLoad  = out_load;
    assign bus.halted   = halted;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_aeolus_control_sequencer.sv
// Bench for aeolus_control_sequencer: two instances (MEM_WAIT=1 and 3) share
// directed stimulus; an instruction-position model is checked every negedge,
// plus hand-computed checks that pin the model.
module tb_aeolus_control_sequencer;

    localparam int NDut  = 2;
    localparam int MIdle = 0;
    localparam int MBusy = 1;
    localparam int MHalt = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       run_s;
    logic       step_s;
    logic       zf_s;
    logic [7:0] instr_s;

    int n_vec = 0;
    int n_bad = 0;

    aeolus_control_sequencer_if bus1 ();
    aeolus_control_sequencer_if bus3 ();

    assign bus1.run      = run_s;
    assign bus1.step     = step_s;
    assign bus1.instr    = instr_s;
    assign bus1.zeroFlag = zf_s;
    assign bus3.run      = run_s;
    assign bus3.step     = step_s;
    assign bus3.instr    = instr_s;
    assign bus3.zeroFlag = zf_s;

    aeolus_control_sequencer #(.MEM_WAIT(1), .WAIT_W(4)) dut1 (
        .boardCLK (clk),
        .reset    (reset),
        .bus      (bus1)
    );

    aeolus_control_sequencer #(.MEM_WAIT(3), .WAIT_W(4)) dut3 (
        .boardCLK (clk),
        .reset    (reset),
        .bus      (bus3)
    );

    logic [13:0] dut_v [NDut];
    assign dut_v[0] = {bus1.pcInc, bus1.pcLoad, bus1.irLoad, bus1.aluOp, bus1.accWrite,
                       bus1.accSel, bus1.outLoad, bus1.halted, bus1.state};
    assign dut_v[1] = {bus3.pcInc, bus3.pcLoad, bus3.irLoad, bus3.aluOp, bus3.accWrite,
                       bus3.accSel, bus3.outLoad, bus3.halted, bus3.state};

    // Model: mode plus position within the current instruction (0 .. w+1).
    int mw     [NDut] = '{1, 3};
    int m_mode [NDut];
    int m_pos  [NDut];
    int m_op   [NDut];

    initial begin
        for (int i = 0; i < NDut; i++) begin
            m_mode[i] = MIdle;
            m_pos[i]  = 0;
            m_op[i]   = 0;
        end
    end

    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < NDut; i++) begin
            if (!reset) begin
                m_mode[i] <= MIdle;
                m_pos[i]  <= 0;
                m_op[i]   <= 0;
            end else if (m_mode[i] == MIdle) begin
                if (run_s || step_s) begin
                    m_mode[i] <= MBusy;
                    m_pos[i]  <= 0;
                end
            end else if (m_mode[i] == MBusy) begin
                if (m_pos[i] == mw[i] - 1) begin
                    m_op[i]  <= int'(instr_s[7:4]);
                    m_pos[i] <= m_pos[i] + 1;
                end else if (m_pos[i] == mw[i]) begin
                    if (m_op[i] == 15) m_mode[i] <= MHalt;
                    else m_pos[i] <= m_pos[i] + 1;
                end else if (m_pos[i] == mw[i] + 1) begin
                    if (run_s) m_pos[i] <= 0;
                    else m_mode[i] <= MIdle;
                end else begin
                    m_pos[i] <= m_pos[i] + 1;
                end
            end
        end
    end

    function automatic logic [13:0] expect_out(input int mode, input int pos, input int op,
                                               input int w, input logic zf);
        logic       pc_inc = 1'b0;
        logic       pc_load = 1'b0;
        logic       ir_load = 1'b0;
        logic [2:0] alu = 3'd0;
        logic       aw = 1'b0;
        logic [1:0] asel = 2'd0;
        logic       ol = 1'b0;
        logic       hl = 1'b0;
        logic [2:0] st = 3'd0;
        if (mode == MHalt) begin
            hl = 1'b1;
            st = 3'd4;
        end else if (mode == MBusy) begin
            if (pos < w) begin
                st = 3'd1;
                if (pos == w - 1) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                end
            end else if (pos == w) begin
                st = 3'd2;
            end else begin
                st = 3'd3;
                if (op == 1) begin
                    aw = 1'b1; asel = 2'd1;
                end else if (op >= 2 && op <= 7) begin
                    aw = 1'b1; alu = 3'(op - 2);
                end else if (op == 8) begin
                    aw = 1'b1; asel = 2'd2;
                end else if (op == 9) begin
                    ol = 1'b1;
                end else if (op == 10) begin
                    pc_load = 1'b1;
                end else if (op == 11) begin
                    pc_load = zf;
                end
            end
        end
        return {pc_inc, pc_load, ir_load, alu, aw, asel, ol, hl, st};
    endfunction

    // Every-cycle comparison against the model, on the falling edge.
    initial begin
        logic [13:0] exp_v;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NDut; i++) begin
                exp_v = expect_out(m_mode[i], m_pos[i], m_op[i], mw[i], zf_s);
                n_vec++;
                if (dut_v[i] !== exp_v) begin
                    n_bad++;
                    $display("FAIL cycle_mw%0d t=%0t: got %h expected %h",
                             mw[i], $time, dut_v[i], exp_v);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int strobe_or;
        int halt_and;
        reset   = 1'b0;
        run_s   = 1'b0;
        step_s  = 1'b0;
        zf_s    = 1'b0;
        instr_s = 8'h00;
        tick(2);
        chk("rst_state1", int'(bus1.state), 0);
        chk("rst_state3", int'(bus3.state), 0);
        chk("rst_strobes1", int'({bus1.pcInc, bus1.pcLoad, bus1.irLoad, bus1.accWrite,
                                  bus1.outLoad, bus1.halted, bus1.aluOp, bus1.accSel}), 0);
        reset = 1'b1;
        tick(1);

        // 1: free run LDI 8; ADD; OUT on MEM_WAIT=1
        run_s   = 1'b1;
        instr_s = 8'h18;
        tick(1);
        chk("t1_fetch_st", int'(bus1.state), 1);
        chk("t1_fetch_ir", int'({bus1.irLoad, bus1.pcInc}), 3);
        tick(2);
        chk("t1_ldi", int'({bus1.accWrite, bus1.accSel}), 5);
        instr_s = 8'h20;
        tick(1);
        chk("t1_fetch2_ir", int'({bus1.irLoad, bus1.pcInc}), 3);
        tick(2);
        chk("t1_add", int'({bus1.accWrite, bus1.accSel, bus1.aluOp}), 32);
        instr_s = 8'h90;
        tick(3);
        chk("t1_out", int'(bus1.outLoad), 1);
        run_s = 1'b0;
        tick(1);
        chk("t1_stop_idle", int'(bus1.state), 0);
        tick(10);

        // 2: single step OUT, then quiet in IDLE
        step_s  = 1'b1;
        instr_s = 8'h98;
        tick(1);
        step_s = 1'b0;
        tick(2);
        chk("t2_out", int'(bus1.outLoad), 1);
        strobe_or = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            strobe_or |= int'({bus1.pcInc, bus1.pcLoad, bus1.irLoad, bus1.accWrite,
                               bus1.outLoad, bus1.state});
        end
        chk("t2_quiet_mw1", strobe_or, 0);
        chk("t2_idle_mw3", int'(bus3.state), 0);

        // 3: JZ with zeroFlag 0 then 1
        instr_s = 8'hB5;
        zf_s    = 1'b0;
        step_s  = 1'b1;
        tick(1);
        step_s = 1'b0;
        tick(2);
        chk("t3_jz_nz_state", int'(bus1.state), 3);
        chk("t3_jz_nz", int'(bus1.pcLoad), 0);
        tick(10);
        zf_s   = 1'b1;
        step_s = 1'b1;
        tick(1);
        step_s = 1'b0;
        tick(2);
        chk("t3_jz_z", int'(bus1.pcLoad), 1);
        tick(10);
        zf_s = 1'b0;

        // 4: MEM_WAIT=3 instance, ADD loop
        instr_s = 8'h20;
        run_s   = 1'b1;
        tick(1);
        chk("t4_f1", int'({bus3.state, bus3.irLoad}), 2);
        tick(1);
        chk("t4_f2", int'({bus3.state, bus3.irLoad}), 2);
        tick(1);
        chk("t4_f3", int'({bus3.state, bus3.irLoad}), 3);
        tick(1);
        chk("t4_dec", int'(bus3.state), 2);
        tick(1);
        chk("t4_exec", int'({bus3.state, bus3.accWrite}), 7);
        tick(3);
        chk("t4_period", int'(bus3.irLoad), 1);
        run_s = 1'b0;
        tick(10);

        // 5: HALT is sticky until reset, which acts asynchronously
        instr_s = 8'hF0;
        run_s   = 1'b1;
        tick(3);
        chk("t5_halt_mw1", int'({bus1.halted, bus1.state}), 12);
        tick(3);
        halt_and = 1;
        for (int k = 0; k < 50; k++) begin
            run_s  = k[0];
            step_s = k[1];
            tick(1);
            halt_and &= int'(bus1.halted & bus3.halted);
        end
        chk("t5_halt_hold", halt_and, 1);
        reset = 1'b0;
        #1;
        chk("t5_async_mw1", int'({bus1.halted, bus1.state}), 0);
        chk("t5_async_mw3", int'({bus3.halted, bus3.state}), 0);
        run_s   = 1'b0;
        step_s  = 1'b0;
        instr_s = 8'h00;
        tick(2);
        reset = 1'b1;
        tick(2);

        // 6: reset during EXEC of ADD, then restart
        instr_s = 8'h20;
        run_s   = 1'b1;
        tick(3);
        chk("t6_exec", int'({bus1.state, bus1.accWrite}), 7);
        reset = 1'b0;
        #1;
        chk("t6_drop", int'({bus1.state, bus1.accWrite}), 0);
        tick(1);
        reset = 1'b1;
        tick(1);
        chk("t6_restart", int'({bus1.state, bus1.irLoad}), 3);
        tick(5);
        run_s = 1'b0;
        tick(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
